// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and program memory write port of the program loader
interface prog_loader_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_wr, mem_addr, mem_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a checksummed byte stream into program memory, then releases the CPU
module prog_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   count,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] sum_q;
  logic [DW-1:0] chk_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          done_q;
  logic [DW-1:0] total_d;

  // the checksum byte is chosen so the whole stream sums to zero
  assign total_d = sum_q + chk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      sum_q      <= '0;
      chk_q      <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (start) begin
            state_q <= LOAD;
            count_q <= '0;
            sum_q   <= '0;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            if (bus.s_last) begin
              chk_q   <= bus.s_data;
              state_q <= CHECK;
            end else if (count_q == DEPTH_C) begin
              state_q <= ERROR;
            end else begin
              mem_wr_q   <= 1'b1;
              mem_addr_q <= count_q[AW-1:0];
              mem_data_q <= bus.s_data;
              count_q    <= count_q + 1'b1;
              sum_q      <= sum_q + bus.s_data;
            end
          end
        end
        CHECK: state_q <= (total_d == '0) ? RUN : ERROR;
        RUN: begin
          if (halt) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready  = (state_q == LOAD);
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign busy         = (state_q == LOAD) || (state_q == CHECK);
  assign cpu_run      = (state_q == RUN);
  assign error        = (state_q == ERROR);
  assign done         = done_q;
  assign count        = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  logic start;
  logic halt;
  logic cpu_run;
  logic busy;
  logic done;
  logic error;
  logic [AW:0] count;

  int n_vec;
  int n_err;

  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];

  prog_loader_if #(.AW(AW), .DW(DW)) bus ();

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .halt    (halt),
    .cpu_run (cpu_run),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .count   (count),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory-side monitor: one entry per cycle the write strobe is high
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_byte_timeout data=%h s_ready never high", d);
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({bus.s_ready, bus.mem_wr, cpu_run, busy, done, error} !== 6'b0 || count !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got ready=%b wr=%b run=%b busy=%b done=%b err=%b count=%0d want all 0",
               bus.s_ready, bus.mem_wr, cpu_run, busy, done, error, count);
    end
  endtask

  task automatic test_good_load;
    logic [DW-1:0] prog[3];
    prog = '{8'hA0, 8'h21, 8'hE0};
    wr_a.delete();
    wr_d.delete();
    do_start();
    for (int i = 0; i < 3; i++) send_byte(prog[i], 1'b0);
    send_byte(8'h5F, 1'b1);
    n_vec++;
    if (cpu_run !== 1'b0 || busy !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL good_check_cycle got run=%b busy=%b ready=%b want 0 1 0", cpu_run, busy, bus.s_ready);
    end
    tick();
    n_vec++;
    if (cpu_run !== 1'b1 || error !== 1'b0 || count !== 6'd3) begin
      n_err++;
      $display("FAIL good_run got run=%b err=%b count=%0d want 1 0 3", cpu_run, error, count);
    end
    n_vec++;
    if (wr_a.size() != 3) begin
      n_err++;
      $display("FAIL good_writes got %0d writes want 3", wr_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (wr_a[i] !== AW'(i) || wr_d[i] !== prog[i]) begin
          n_err++;
          $display("FAIL good_write%0d got addr=%0d data=%h want %0d %h", i, wr_a[i], wr_d[i], i, prog[i]);
        end
      end
    end
  endtask

  task automatic test_run_end;
    do_start();
    n_vec++;
    if (cpu_run !== 1'b1 || busy !== 1'b0 || count !== 6'd3) begin
      n_err++;
      $display("FAIL start_in_run got run=%b busy=%b count=%0d want 1 0 3", cpu_run, busy, count);
    end
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_vec++;
    if (cpu_run !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_err++;
      $display("FAIL halt_edge got run=%b done=%b busy=%b err=%b want 0 1 0 0", cpu_run, done, busy, error);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || cpu_run !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse got done=%b run=%b want 0 0", done, cpu_run);
    end
  endtask

  task automatic test_bad_checksum;
    wr_a.delete();
    wr_d.delete();
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h60, 1'b1);
    tick();
    n_vec++;
    if (error !== 1'b1 || cpu_run !== 1'b0 || count !== 6'd3 || wr_a.size() != 3) begin
      n_err++;
      $display("FAIL bad_checksum got err=%b run=%b count=%0d writes=%0d want 1 0 3 3",
               error, cpu_run, count, wr_a.size());
    end
    repeat (3) tick();
    n_vec++;
    if (error !== 1'b1 || cpu_run !== 1'b0) begin
      n_err++;
      $display("FAIL error_sticky got err=%b run=%b want 1 0", error, cpu_run);
    end
    do_start();
    n_vec++;
    if (error !== 1'b0 || count !== '0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_clears got err=%b count=%0d busy=%b want 0 0 1", error, count, busy);
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b1);
    tick();
    n_vec++;
    if (cpu_run !== 1'b1 || count !== 6'd1) begin
      n_err++;
      $display("FAIL reload_run got run=%b count=%0d want 1 1", cpu_run, count);
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic test_overflow;
    logic [DW-1:0] prog[33];
    for (int i = 0; i < 33; i++) prog[i] = DW'($urandom);
    wr_a.delete();
    wr_d.delete();
    do_start();
    for (int i = 0; i < 33; i++) send_byte(prog[i], 1'b0);
    n_vec++;
    if (error !== 1'b1 || count !== 6'd32 || bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_state got err=%b count=%0d ready=%b want 1 32 0", error, count, bus.s_ready);
    end
    repeat (2) tick();
    n_vec++;
    if (wr_a.size() != DEPTH) begin
      n_err++;
      $display("FAIL overflow_writes got %0d writes want %0d", wr_a.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_vec++;
        if (wr_a[i] !== AW'(i) || wr_d[i] !== prog[i]) begin
          n_err++;
          $display("FAIL overflow_write%0d got addr=%0d data=%h want %0d %h", i, wr_a[i], wr_d[i], i, prog[i]);
        end
      end
    end
  endtask

  task automatic test_gaps;
    wr_a.delete();
    wr_d.delete();
    do_start();
    send_byte(8'h11, 1'b0);
    tick();
    tick();
    n_vec++;
    if (wr_a.size() != 1 || count !== 6'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL gap_idle got writes=%0d count=%0d busy=%b want 1 1 1", wr_a.size(), count, busy);
    end
    send_byte(8'h22, 1'b0);
    send_byte(8'hCD, 1'b1);
    tick();
    n_vec++;
    if (wr_a.size() != 2 || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL gap_writes got writes=%0d run=%b want 2 1", wr_a.size(), cpu_run);
    end else begin
      n_vec++;
      if (wr_a[0] !== 5'd0 || wr_d[0] !== 8'h11 || wr_a[1] !== 5'd1 || wr_d[1] !== 8'h22) begin
        n_err++;
        $display("FAIL gap_data got %0d:%h %0d:%h want 0:11 1:22", wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int len;
      int exp_cnt;
      bit good;
      bit exp_err;
      logic [DW-1:0] chk;
      logic [DW-1:0] prog[$];
      int sum;
      len  = (it == 0) ? 0 : $urandom_range(0, 33);
      good = (it == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      prog.delete();
      sum = 0;
      for (int i = 0; i < len; i++) begin
        prog.push_back(DW'($urandom));
        sum += int'(prog[i]);
      end
      chk = DW'((256 - (sum % 256)) % 256);
      if (!good) chk = chk + DW'($urandom_range(1, 255));
      exp_err = (len > DEPTH) || !good;
      exp_cnt = (len > DEPTH) ? DEPTH : len;
      wr_a.delete();
      wr_d.delete();
      do_start();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(prog[i], 1'b0);
      end
      if (len <= DEPTH) send_byte(chk, 1'b1);
      tick();
      n_vec++;
      if (error !== exp_err || cpu_run !== !exp_err || count !== (AW+1)'(exp_cnt)) begin
        n_err++;
        $display("FAIL rand%0d_result len=%0d got err=%b run=%b count=%0d want %b %b %0d",
                 it, len, error, cpu_run, count, exp_err, !exp_err, exp_cnt);
      end
      n_vec++;
      if (wr_a.size() != exp_cnt) begin
        n_err++;
        $display("FAIL rand%0d_nwrites got %0d want %0d", it, wr_a.size(), exp_cnt);
      end else begin
        for (int i = 0; i < exp_cnt; i++) begin
          if (wr_a[i] !== AW'(i) || wr_d[i] !== prog[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL rand%0d_write%0d got %0d:%h want %0d:%h", it, i, wr_a[i], wr_d[i], i, prog[i]);
          end
        end
      end
      if (!exp_err) begin
        repeat ($urandom_range(0, 3)) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_vec++;
        if (done !== 1'b1 || cpu_run !== 1'b0) begin
          n_err++;
          $display("FAIL rand%0d_halt got done=%b run=%b want 1 0", it, done, cpu_run);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    wr_a.delete();
    wr_d.delete();
    do_start();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.s_ready !== 1'b0 || bus.mem_wr !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL async_reset got ready=%b wr=%b busy=%b count=%0d want 0 0 0 0",
               bus.s_ready, bus.mem_wr, busy, count);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_a.delete();
    wr_d.delete();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    repeat (4) tick();
    bus.s_valid = 1'b0;
    tick();
    n_vec++;
    if (wr_a.size() != 0 || busy !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle got writes=%0d busy=%b count=%0d want 0 0 0", wr_a.size(), busy, count);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    halt = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    #2 rst = 1'b0;
    #1 test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    test_good_load();
    test_run_end();
    test_bad_checksum();
    test_overflow();
    test_gaps();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule
